// File: rtl/hessian_nms_3x3_if.sv
// detH pixel stream in, keypoint strobe and frame-done pulse out.
interface hessian_nms_3x3_if #(
  parameter int DATA_WIDTH = 28,
  parameter int X_W        = 10,
  parameter int Y_W        = 9
);
  logic                    din_valid;
  logic [DATA_WIDTH+3:0]   din;
  logic                    sof;
  logic                    o_kp_valid;
  logic [X_W-1:0]          o_kp_x;
  logic [Y_W-1:0]          o_kp_y;
  logic [DATA_WIDTH+3:0]   o_kp_det;
  logic                    o_frame_done;

  modport master (
    output din_valid, din, sof,
    input  o_kp_valid, o_kp_x, o_kp_y, o_kp_det, o_frame_done
  );

  modport slave (
    input  din_valid, din, sof,
    output o_kp_valid, o_kp_x, o_kp_y, o_kp_det, o_frame_done
  );
endinterface

// File: rtl/hessian_nms_3x3.sv
// 3x3 non-maximum suppression over a raster detH stream; emits strict local maxima above THRESHOLD.
// Latency 2 cycles from accept to o_kp_valid/o_frame_done; no backpressure, one pixel per din_valid.
module hessian_nms_3x3 #(
  parameter int DATA_WIDTH = 28,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int THRESHOLD  = 0,
  parameter int X_W        = 10,
  parameter int Y_W        = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  hessian_nms_3x3_if.slave   io
);

  localparam int DW = DATA_WIDTH + 4;
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic signed [DW-1:0] THR = DW'(THRESHOLD);
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

  logic                  accept;
  logic [X_W-1:0]        x_cnt, pos_x;
  logic [Y_W-1:0]        y_cnt, pos_y;
  logic [AW-1:0]         col;
  logic [DW-1:0]         row1, row2;
  logic [DW-1:0]         lb_new [IMG_WIDTH];
  logic [DW-1:0]         lb_old [IMG_WIDTH];
  logic signed [DW-1:0]  win [3][3];

  logic                  s1_vld, s1_fd;
  logic [X_W-1:0]        s1_x;
  logic [Y_W-1:0]        s1_y;

  logic signed [DW-1:0]  centre;
  logic                  is_peak;

  logic                  kp_vld_q, fd_q;
  logic [X_W-1:0]        kp_x_q;
  logic [Y_W-1:0]        kp_y_q;
  logic [DW-1:0]         kp_det_q;

  assign accept = io.din_valid;
  // sof overrides the counters so a new frame can start anywhere
  assign pos_x  = io.sof ? '0 : x_cnt;
  assign pos_y  = io.sof ? '0 : y_cnt;
  assign col    = pos_x[AW-1:0];
  assign row1   = lb_new[col];
  assign row2   = lb_old[col];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      if (pos_x == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= (pos_y == Y_LAST) ? '0 : pos_y + Y_W'(1);
      end else begin
        x_cnt <= pos_x + X_W'(1);
        y_cnt <= pos_y;
      end
    end
  end

  // Row storage is never reset; the y<2 evaluation mask hides stale contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_old[col] <= row1;
      lb_new[col] <= io.din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= $signed(row2);
      win[1][2] <= $signed(row1);
      win[2][2] <= $signed(io.din);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_fd  <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
    end else begin
      s1_vld <= accept && (pos_x >= X_W'(2)) && (pos_y >= Y_W'(2));
      s1_fd  <= accept && (pos_x == X_LAST) && (pos_y == Y_LAST);
      if (accept) begin
        s1_x <= pos_x - X_W'(1);
        s1_y <= pos_y - Y_W'(1);
      end
    end
  end

  // Strict comparison: any tie with a neighbour suppresses the centre.
  always_comb begin
    centre  = win[1][1];
    is_peak = (centre > THR);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!(r == 1 && c == 1) && !(centre > win[r][c])) begin
          is_peak = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp_vld_q <= 1'b0;
      fd_q     <= 1'b0;
      kp_x_q   <= '0;
      kp_y_q   <= '0;
      kp_det_q <= '0;
    end else begin
      kp_vld_q <= s1_vld && is_peak;
      fd_q     <= s1_fd;
      if (s1_vld && is_peak) begin
        kp_x_q   <= s1_x;
        kp_y_q   <= s1_y;
        kp_det_q <= centre;
      end
    end
  end

  assign io.o_kp_valid   = kp_vld_q;
  assign io.o_frame_done = fd_q;
  assign io.o_kp_x       = kp_x_q;
  assign io.o_kp_y       = kp_y_q;
  assign io.o_kp_det     = kp_det_q;

endmodule

// File: tb/tb_hessian_nms_3x3.sv
// Bench for hessian_nms_3x3: two instances (THRESHOLD 0 and -10) share one stimulus stream,
// checked every cycle against a frame-array model plus hand-computed expectations.
module tb_hessian_nms_3x3;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 32;
  localparam int NC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          din_valid;
  logic [DW-1:0] din;
  logic          sof;
  int            cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  hessian_nms_3x3_if #(.DATA_WIDTH(28), .X_W(10), .Y_W(9)) if0 ();
  hessian_nms_3x3_if #(.DATA_WIDTH(28), .X_W(10), .Y_W(9)) if1 ();
  assign if0.din_valid = din_valid;
  assign if0.din       = din;
  assign if0.sof       = sof;
  assign if1.din_valid = din_valid;
  assign if1.din       = din;
  assign if1.sof       = sof;

  hessian_nms_3x3 #(.DATA_WIDTH(28), .IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(0),
                    .X_W(10), .Y_W(9)) dut0 (.clk(clk), .rst_n(rst_n), .io(if0));
  hessian_nms_3x3 #(.DATA_WIDTH(28), .IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(-10),
                    .X_W(10), .Y_W(9)) dut1 (.clk(clk), .rst_n(rst_n), .io(if1));

  logic          kv [2];
  logic          kf [2];
  logic [9:0]    kx [2];
  logic [8:0]    ky [2];
  logic [DW-1:0] kd [2];
  assign kv[0] = if0.o_kp_valid;   assign kv[1] = if1.o_kp_valid;
  assign kf[0] = if0.o_frame_done; assign kf[1] = if1.o_frame_done;
  assign kx[0] = if0.o_kp_x;       assign kx[1] = if1.o_kp_x;
  assign ky[0] = if0.o_kp_y;       assign ky[1] = if1.o_kp_y;
  assign kd[0] = if0.o_kp_det;     assign kd[1] = if1.o_kp_det;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  // Model: the frame as a 2D array, keypoints judged directly from the neighbourhood rule.
  int            pix [H][W];
  int            mx = 0, my = 0;
  int            thr [2] = '{0, -10};
  bit            ev  [2][NC];
  int            ex_x [2][NC];
  int            ex_y [2][NC];
  logic [DW-1:0] ex_d [2][NC];
  bit            efd [NC];

  task automatic model_accept(input int c, input logic [DW-1:0] v, input logic s);
    int px, py, ctr;
    bit pk;
    if (s) begin mx = 0; my = 0; end
    px = mx; py = my;
    pix[py][px] = $signed(v);
    if (px >= 2 && py >= 2) begin
      ctr = pix[py-1][px-1];
      for (int d = 0; d < 2; d++) begin
        pk = (ctr > thr[d]);
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dy != 0 || dx != 0) && !(ctr > pix[py-1+dy][px-1+dx])) pk = 0;
        if (pk) begin
          ev[d][c+2]   = 1;
          ex_x[d][c+2] = px - 1;
          ex_y[d][c+2] = py - 1;
          ex_d[d][c+2] = ctr;
        end
      end
    end
    if (px == W-1 && py == H-1) efd[c+2] = 1;
    mx = px + 1;
    if (mx == W) begin
      mx = 0;
      my = py + 1;
      if (my == H) my = 0;
    end
  endtask

  logic [31:0] hx [2], hy [2], hd [2];
  int kp_cnt [2] = '{0, 0};
  int fd_cnt [2] = '{0, 0};
  int lx [2], ly [2], lc [2], fdc [2];
  logic [DW-1:0] ld [2];
  int qx [$], qy [$];

  initial begin
    for (int d = 0; d < 2; d++) begin hx[d] = 0; hy[d] = 0; hd[d] = 0; end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        hx[d] = 0; hy[d] = 0; hd[d] = 0;
        chk("reset kp_valid", d, 32'(kv[d]), 32'd0);
        chk("reset frame_done", d, 32'(kf[d]), 32'd0);
      end else begin
        if (ev[d][cyc]) begin
          hx[d] = ex_x[d][cyc]; hy[d] = ex_y[d][cyc]; hd[d] = ex_d[d][cyc];
        end
        chk("kp_valid", d, 32'(kv[d]), 32'(ev[d][cyc]));
        chk("frame_done", d, 32'(kf[d]), 32'(efd[cyc]));
      end
      chk("kp_x", d, 32'(kx[d]), hx[d]);
      chk("kp_y", d, 32'(ky[d]), hy[d]);
      chk("kp_det", d, kd[d], hd[d]);
      if (kv[d] === 1'b1) begin
        kp_cnt[d]++;
        lx[d] = int'(kx[d]); ly[d] = int'(ky[d]); ld[d] = kd[d]; lc[d] = cyc;
        if (d == 0) begin qx.push_back(int'(kx[d])); qy.push_back(int'(ky[d])); end
      end
      if (kf[d] === 1'b1) begin fd_cnt[d]++; fdc[d] = cyc; end
    end
  end

  int frm [W*H];
  int acc_cyc [W*H];

  task automatic fill(input int bg);
    for (int i = 0; i < W*H; i++) frm[i] = bg;
  endtask

  task automatic setp(input int x, input int y, input int v);
    frm[y*W + x] = v;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic s);
    @(posedge clk);
    #1;
    din_valid = v; din = d; sof = s;
    if (v) model_accept(cyc, d, s);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0);
  endtask

  task automatic stream(input bit gaps, input int npx);
    for (int i = 0; i < npx; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, '0, 1'b0);
      drive(1'b1, frm[i], i == 0);
      acc_cyc[i] = cyc;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n = 1'b0; din_valid = 1'b0; sof = 1'b0;
    for (int i = cyc; i < NC; i++) begin
      ev[0][i] = 0; ev[1][i] = 0; efd[i] = 0;
    end
    mx = 0; my = 0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int k0, k1, f0, qs;

  initial begin
    rst_n = 1'b1; din_valid = 1'b0; din = '0; sof = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // single peak
    k0 = kp_cnt[0]; k1 = kp_cnt[1]; f0 = fd_cnt[0];
    fill(10); setp(4, 3, 500);
    stream(0, W*H); idle(4);
    chk("s1 kp count", 0, kp_cnt[0] - k0, 1);
    chk("s1 kp x", 0, lx[0], 4);
    chk("s1 kp y", 0, ly[0], 3);
    chk("s1 kp det", 0, ld[0], 500);
    chk("s1 kp cycle", 0, lc[0], acc_cyc[4*W+5] + 2);
    chk("s1 fd count", 0, fd_cnt[0] - f0, 1);
    chk("s1 fd cycle", 0, fdc[0], acc_cyc[W*H-1] + 2);
    chk("s1 kp count", 1, kp_cnt[1] - k1, 1);

    // threshold and sign
    k0 = kp_cnt[0]; k1 = kp_cnt[1];
    fill(-100); setp(3, 2, -5);
    stream(0, W*H); idle(4);
    chk("s2 kp count thr0", 0, kp_cnt[0] - k0, 0);
    chk("s2 kp count thr-10", 1, kp_cnt[1] - k1, 1);
    chk("s2 kp x", 1, lx[1], 3);
    chk("s2 kp y", 1, ly[1], 2);
    chk("s2 kp det", 1, ld[1], 32'hfffffffb);

    // plateau
    k0 = kp_cnt[0]; k1 = kp_cnt[1];
    fill(10); setp(3, 3, 200); setp(4, 3, 200);
    stream(0, W*H); idle(4);
    chk("s3 plateau count", 0, kp_cnt[0] - k0, 0);
    chk("s3 plateau count", 1, kp_cnt[1] - k1, 0);

    // border peaks
    k0 = kp_cnt[0]; k1 = kp_cnt[1];
    fill(10); setp(0, 2, 300); setp(7, 4, 300); setp(5, 0, 300); setp(5, 5, 300);
    stream(0, W*H); idle(4);
    chk("s3 border count", 0, kp_cnt[0] - k0, 0);
    chk("s3 border count", 1, kp_cnt[1] - k1, 0);

    // first evaluable centre
    k0 = kp_cnt[0];
    fill(10); setp(1, 1, 300);
    stream(0, W*H); idle(4);
    chk("s3 corner count", 0, kp_cnt[0] - k0, 1);
    chk("s3 corner x", 0, lx[0], 1);
    chk("s3 corner y", 0, ly[0], 1);

    // valid gaps
    k0 = kp_cnt[0];
    fill(10); setp(4, 3, 500);
    stream(1, W*H); idle(4);
    chk("s4 kp count", 0, kp_cnt[0] - k0, 1);
    chk("s4 kp x", 0, lx[0], 4);
    chk("s4 kp y", 0, ly[0], 3);
    chk("s4 kp cycle", 0, lc[0], acc_cyc[4*W+5] + 2);

    // reset mid-frame, then restream
    k0 = kp_cnt[0];
    fill(10); setp(4, 3, 500);
    stream(0, 20);
    do_reset(3);
    idle(2);
    stream(0, W*H); idle(4);
    chk("s5 kp count", 0, kp_cnt[0] - k0, 1);
    chk("s5 kp x", 0, lx[0], 4);
    chk("s5 kp y", 0, ly[0], 3);
    chk("s5 kp cycle", 0, lc[0], acc_cyc[4*W+5] + 2);

    // back-to-back frames
    qs = qx.size(); f0 = fd_cnt[0];
    fill(10); setp(4, 3, 500);
    stream(0, W*H);
    fill(10); setp(2, 2, 500);
    stream(0, W*H); idle(4);
    chk("s6 kp count", 0, qx.size() - qs, 2);
    if (qx.size() - qs == 2) begin
      chk("s6 first x", 0, qx[qs], 4);
      chk("s6 first y", 0, qy[qs], 3);
      chk("s6 second x", 0, qx[qs+1], 2);
      chk("s6 second y", 0, qy[qs+1], 2);
    end
    chk("s6 fd count", 0, fd_cnt[0] - f0, 2);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
